// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if
//
// Bundles every non-clock signal of the operand-fetch stage:
//   - decoded-instruction input side : in_valid/in_ready, rs1_addr, rs2_addr,
//                                      imm, pc, src_a_sel, src_b_sel, alu_op
//   - ALU output side                : out_valid/out_ready, A, B, Upr_ALU,
//                                      rs2_val
//   - write-back side                : wb_en, wb_addr, wb_data
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holding valid = 1 keeps its
// payload stable until that edge; ready may depend combinationally on
// state, never on the same side's valid.
//
// Modports:
//   slave  - the operand stage itself
//   master - the surroundings (decoder, ALU, write-back) or a testbench
// ---------------------------------------------------------------------------
interface alu_operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
);
    localparam int AW = $clog2(NREG);

    // decoded-instruction side
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [1:0]       src_a_sel;
    logic [1:0]       src_b_sel;
    logic [4:0]       alu_op;

    // ALU side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       Upr_ALU;
    logic [WIDTH-1:0] rs2_val;

    // write-back side
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, imm, pc, src_a_sel, src_b_sel, alu_op,
        output in_ready,
        output out_valid, A, B, Upr_ALU, rs2_val,
        input  out_ready,
        input  wb_en, wb_addr, wb_data
    );

    modport master (
        output in_valid, rs1_addr, rs2_addr, imm, pc, src_a_sel, src_b_sel, alu_op,
        input  in_ready,
        input  out_valid, A, B, Upr_ALU, rs2_val,
        output out_ready,
        output wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Operand-fetch stage in front of the ALU. Holds the integer register file
// (register 0 hardwired to zero), selects operand A from rs1/pc/zero and
// operand B from rs2/imm/constant 4/zero, and presents a registered
// {A, B, Upr_ALU, rs2_val} bundle to the ALU through a valid/ready
// handshake. Write-back data is forwarded into same-cycle operand reads.
//
// Ports:
//   clk    - rising-edge clock for all state
//   rst_n  - asynchronous active-low reset; clears bundle and register file
//   bus    - alu_operand_stage_if.slave (instruction in, bundle out,
//            write-back)
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_operand_stage_if.slave    bus
);
    localparam int AW = $clog2(NREG);

    localparam logic [1:0] SEL_A_RS1  = 2'd0;
    localparam logic [1:0] SEL_A_PC   = 2'd1;
    localparam logic [1:0] SEL_B_RS2  = 2'd0;
    localparam logic [1:0] SEL_B_IMM  = 2'd1;
    localparam logic [1:0] SEL_B_FOUR = 2'd2;

    localparam logic [WIDTH-1:0] CONST_FOUR = WIDTH'(4);

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] regs [NREG];

    // Index 0 is never written, so it stays at its reset value of zero.
    // The write port is gated by reset through the asynchronous clear, so
    // write-back during reset has no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_addr != '0)) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports with write-back bypass
    // -----------------------------------------------------------------------
    logic             wb_hit_rs1;
    logic             wb_hit_rs2;
    logic [WIDTH-1:0] rs1_rd;
    logic [WIDTH-1:0] rs2_rd;

    // A write-back to x0 never matches, so x0 always reads zero even while
    // something is trying to write it.
    assign wb_hit_rs1 = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == bus.rs1_addr);
    assign wb_hit_rs2 = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == bus.rs2_addr);

    always_comb begin
        rs1_rd = '0;
        if (bus.rs1_addr == '0) begin
            rs1_rd = '0;
        end else if (wb_hit_rs1) begin
            rs1_rd = bus.wb_data;
        end else begin
            rs1_rd = regs[bus.rs1_addr];
        end
    end

    always_comb begin
        rs2_rd = '0;
        if (bus.rs2_addr == '0) begin
            rs2_rd = '0;
        end else if (wb_hit_rs2) begin
            rs2_rd = bus.wb_data;
        end else begin
            rs2_rd = regs[bus.rs2_addr];
        end
    end

    // -----------------------------------------------------------------------
    // Operand selection (reserved encodings yield zero)
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    always_comb begin
        a_next = '0;
        case (bus.src_a_sel)
            SEL_A_RS1: a_next = rs1_rd;
            SEL_A_PC:  a_next = bus.pc;
            default:   a_next = '0;
        endcase
    end

    always_comb begin
        b_next = '0;
        case (bus.src_b_sel)
            SEL_B_RS2:  b_next = rs2_rd;
            SEL_B_IMM:  b_next = bus.imm;
            SEL_B_FOUR: b_next = CONST_FOUR;
            default:    b_next = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output pipeline register and handshake
    // -----------------------------------------------------------------------
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] rs2_q;
    logic             accept;

    // The slot is free when empty or when the ALU drains it this same edge,
    // which gives full throughput with out_ready held high.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Payload only moves on accept, so a stalled bundle stays bit-stable even
    // while the register file underneath it is being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            rs2_q <= '0;
        end else if (accept) begin
            a_q   <= a_next;
            b_q   <= b_next;
            op_q  <= bus.alu_op;
            rs2_q <= rs2_rd;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.Upr_ALU   = op_q;
    assign bus.rs2_val   = rs2_q;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage directly upstream of the ALU. Holds the 32×32 integer register file, selects the ALU operands from registers, PC, immediate or constants, and presents a registered operand/opcode bundle on the ALU inputs through a valid/ready handshake. It accepts write-back from later stages and forwards same-cycle write data into operand reads.

## Interface
Parameters:
- WIDTH, 32, datapath width; fixed at 32 for this core.
- NREG, 32, register count; register 0 is hardwired zero.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- rs1_addr  in  5  source register 1 index
- rs2_addr  in  5  source register 2 index
- imm  in  32  sign-extended immediate from decoder
- pc  in  32  PC of the instruction
- src_a_sel  in  2  0 = rs1, 1 = pc, 2 = zero, 3 = zero (reserved)
- src_b_sel  in  2  0 = rs2, 1 = imm, 2 = constant 4, 3 = zero (reserved)
- alu_op  in  5  ALU operation code (ALU encoding, passed through unchanged)
- out_valid  out  1  A/B/Upr_ALU bundle valid
- out_ready  in  1  ALU/execute stage accepts bundle
- A  out  32  ALU operand A
- B  out  32  ALU operand B
- Upr_ALU  out  5  ALU operation code
- rs2_val  out  32  registered rs2 value (store data), independent of src_b_sel
- wb_en  in  1  write-back enable
- wb_addr  in  5  write-back register index
- wb_data  in  32  write-back data

## Operation
- Register file: 32 entries × 32 bit. Write on clk rising edge when wb_en = 1 and wb_addr ≠ 0; writes to index 0 are discarded.
- Reads combinational. Index 0 always reads 0.
- Bypass: if wb_en = 1 and wb_addr = rs addr and wb_addr ≠ 0, the read returns wb_data in the same cycle, not the stored value.
- Operand A mux by src_a_sel; operand B mux by src_b_sel; reserved selects yield 0.
- Output register: single pipeline register holding A, B, Upr_ALU, rs2_val, out_valid.
- Handshake: in_ready = ~out_valid | out_ready. Accept = in_valid & in_ready: bundle captured at the edge, out_valid ← 1. Otherwise if out_ready = 1, out_valid ← 0.
- While out_valid = 1 and out_ready = 0: A, B, Upr_ALU, rs2_val held bit-stable; register-file writes still occur but do not alter the held bundle. RAW hazards against a held bundle are the upstream hazard unit's responsibility.
- No arithmetic in this block; all values pass unmodified (constant 4 is zero-extended).
- Inputs ignored when in_valid = 0; no capture, bundle registers unchanged.

## Timing
- Reset (rst_n = 0, asynchronous, any time): out_valid = 0, A = 0, B = 0, Upr_ALU = 5'b00000, rs2_val = 0, all registers = 0. in_ready = 1 during and after reset.
- Reset mid-transfer: held bundle discarded; first post-reset accept occurs on the first edge with rst_n = 1 and in_valid = 1.
- Latency: accept at edge N → out_valid and bundle visible after edge N.
- Throughput: one instruction per cycle when out_ready held 1 (in_ready stays 1 with out_valid = 1).
- Simultaneous accept and write-back to a source register: captured operand is wb_data (bypass); stored value updates on the same edge.
- Simultaneous accept and downstream take (out_valid = 1, out_ready = 1, in_valid = 1): old bundle consumed, new bundle loaded, out_valid stays 1.
- Write-back during reset is ignored.

## Test plan
- Reset: assert rst_n = 0 mid-stream with out_valid = 1 -> out_valid, A, B, Upr_ALU, rs2_val read 0 immediately; reading x5 after reset returns 0.
- Write/read: wb x5 = 0x0000_1234, next cycle rs1 = 5, src_a_sel = 0, src_b_sel = 1, imm = 0xFFFF_FFFC, alu_op = 5'b00000 -> one cycle later A = 0x1234, B = 0xFFFF_FFFC, Upr_ALU = 0.
- x0 and bypass: wb x0 = 0xDEAD_BEEF, then rs1 = 0 -> A = 0; same-cycle wb x7 = 0xA5A5_A5A5 with rs2 = 7, src_b_sel = 0 -> B = 0xA5A5_A5A5, rs2_val = 0xA5A5_A5A5.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, bundle stable, wb to rs1 does not alter A; out_ready = 1 -> next instruction captured at that edge.
- Streaming: 8 back-to-back instructions, out_ready = 1 -> 8 consecutive out_valid cycles, bundles in order; src_a_sel = 1, src_b_sel = 2, pc = 0x100 -> A = 0x100, B = 4.
- Reserved selects: src_a_sel = 3, src_b_sel = 3 with nonzero registers -> A = 0, B = 0.
